// File: rtl/timer_avalon_master_if.sv
// Command/response and Avalon-MM bus bundle for timer_avalon_master.
// master modport is the controller's view; slave is the surrounding system's view.
interface timer_avalon_master_if #(
    parameter int CMD_W = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_op;
    logic [31:0]      cmd_period;
    logic             cmd_continuous;
    logic             cmd_irq_en;

    logic             rsp_valid;
    logic [31:0]      rsp_data;

    logic [2:0]       av_address;
    logic             av_chipselect;
    logic             av_write_n;
    logic [15:0]      av_writedata;
    logic [15:0]      av_readdata;
    logic             av_irq;

    logic             timeout_pulse;
    logic [15:0]      irq_count;

    modport master (
        input  cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
        input  av_readdata, av_irq,
        output cmd_ready, rsp_valid, rsp_data,
        output av_address, av_chipselect, av_write_n, av_writedata,
        output timeout_pulse, irq_count
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
        output av_readdata, av_irq,
        input  cmd_ready, rsp_valid, rsp_data,
        input  av_address, av_chipselect, av_write_n, av_writedata,
        input  timeout_pulse, irq_count
    );
endinterface

// File: rtl/timer_avalon_master.sv
// Command-driven Avalon-MM initiator for a 16-bit interval-timer responder.
// Define TMR_MST_AUTO_ACK_EN to service responder interrupts automatically in IDLE.
module timer_avalon_master #(
    parameter int CMD_W = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    timer_avalon_master_if.master bus
);
    localparam logic [CMD_W-1:0] OP_START  = CMD_W'(0);
    localparam logic [CMD_W-1:0] OP_STOP   = CMD_W'(1);
    localparam logic [CMD_W-1:0] OP_SNAP   = CMD_W'(2);
    localparam logic [CMD_W-1:0] OP_STATUS = CMD_W'(3);

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_PERL   = 3'd2;
    localparam logic [2:0] A_PERH   = 3'd3;
    localparam logic [2:0] A_SNAPL  = 3'd4;
    localparam logic [2:0] A_SNAPH  = 3'd5;

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTL, WR_SNAP, RD_SL, RD_SH, CAP,
        RD_ST, CAP_ST, CLR_ST, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        ready_en_q;
    logic        stop_q;
    logic        auto_q;
    logic [31:0] period_q;
    logic        cont_q;
    logic        ien_q;
    logic [15:0] snap_lo_q;
    logic [1:0]  st_q;
    logic [31:0] rsp_data_q;
    logic [15:0] irq_count_q;

    logic irq_pend;
    logic irq_take;
    logic cmd_take;

`ifdef TMR_MST_AUTO_ACK_EN
    assign irq_pend = bus.av_irq;
`else
    logic unused_av_irq;
    assign irq_pend      = 1'b0;
    assign unused_av_irq = bus.av_irq;
`endif

    // ready_en_q keeps cmd_ready low through reset and until the first edge after it.
    assign bus.cmd_ready     = ready_en_q && (state_q == IDLE) && !irq_pend;
    assign bus.rsp_valid     = (state_q == DONE) && !auto_q;
    assign bus.timeout_pulse = (state_q == DONE) && auto_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.irq_count     = irq_count_q;

    always_comb begin
        state_d  = state_q;
        irq_take = 1'b0;
        cmd_take = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ready_en_q && irq_pend) begin
                    irq_take = 1'b1;
                    state_d  = RD_ST;
                end else if (ready_en_q && bus.cmd_valid) begin
                    cmd_take = 1'b1;
                    if (bus.cmd_op == OP_START)       state_d = WR_PL;
                    else if (bus.cmd_op == OP_STOP)   state_d = WR_CTL;
                    else if (bus.cmd_op == OP_SNAP)   state_d = WR_SNAP;
                    else if (bus.cmd_op == OP_STATUS) state_d = RD_ST;
                    else                              state_d = DONE;
                end
            end
            WR_PL:   state_d = WR_PH;
            WR_PH:   state_d = WR_CTL;
            WR_CTL:  state_d = DONE;
            WR_SNAP: state_d = RD_SL;
            RD_SL:   state_d = RD_SH;
            RD_SH:   state_d = CAP;
            CAP:     state_d = DONE;
            RD_ST:   state_d = CAP_ST;
            CAP_ST:  state_d = CLR_ST;
            CLR_ST:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs decode straight from the state register: one cycle per access.
    always_comb begin
        bus.av_chipselect = 1'b0;
        bus.av_write_n    = 1'b1;
        bus.av_address    = 3'd0;
        bus.av_writedata  = 16'h0000;
        unique case (state_q)
            WR_PL: begin
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                bus.av_address    = A_PERL;
                bus.av_writedata  = period_q[15:0];
            end
            WR_PH: begin
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                bus.av_address    = A_PERH;
                bus.av_writedata  = period_q[31:16];
            end
            WR_CTL: begin
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                bus.av_address    = A_CTRL;
                bus.av_writedata  = {12'h000, stop_q, !stop_q, cont_q, ien_q};
            end
            WR_SNAP: begin
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                bus.av_address    = A_SNAPL;
            end
            RD_SL: begin
                bus.av_chipselect = 1'b1;
                bus.av_address    = A_SNAPL;
            end
            RD_SH: begin
                bus.av_chipselect = 1'b1;
                bus.av_address    = A_SNAPH;
            end
            RD_ST: begin
                bus.av_chipselect = 1'b1;
                bus.av_address    = A_STATUS;
            end
            CLR_ST: begin
                // Only acknowledge a timeout that was actually seen.
                if (st_q[0]) begin
                    bus.av_chipselect = 1'b1;
                    bus.av_write_n    = 1'b0;
                    bus.av_address    = A_STATUS;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ready_en_q  <= 1'b0;
            stop_q      <= 1'b0;
            auto_q      <= 1'b0;
            period_q    <= 32'h0;
            cont_q      <= 1'b0;
            ien_q       <= 1'b0;
            snap_lo_q   <= 16'h0;
            st_q        <= 2'b00;
            rsp_data_q  <= 32'h0;
            irq_count_q <= 16'h0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (cmd_take) begin
                stop_q <= (bus.cmd_op == OP_STOP);
                auto_q <= 1'b0;
                if (bus.cmd_op == OP_START) begin
                    period_q <= bus.cmd_period;
                    cont_q   <= bus.cmd_continuous;
                    ien_q    <= bus.cmd_irq_en;
                end
            end
            if (irq_take) begin
                auto_q <= 1'b1;
            end
            if (state_q == RD_SH) begin
                snap_lo_q <= bus.av_readdata;
            end
            if (state_q == CAP) begin
                rsp_data_q <= {bus.av_readdata, snap_lo_q};
            end
            if (state_q == CAP_ST) begin
                st_q <= bus.av_readdata[1:0];
            end
            // Automatic acknowledges leave the command result untouched.
            if ((state_q == CLR_ST) && !auto_q) begin
                rsp_data_q <= {30'h0, st_q};
            end
            if ((state_q == DONE) && auto_q) begin
                irq_count_q <= irq_count_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_timer_avalon_master.sv
// Bench for timer_avalon_master: behavioural interval-timer responder plus a
// transaction-level expectation model of each command's bus cycles and result.
module tb_timer_avalon_master;
    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_STOP   = 2'd1;
    localparam logic [1:0] OP_SNAP   = 2'd2;
    localparam logic [1:0] OP_STATUS = 2'd3;
    localparam logic [20:0] IDLE_B   = {1'b0, 1'b1, 3'd0, 16'h0000};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    timer_avalon_master_if #(.CMD_W(2)) bus ();
    timer_avalon_master #(.CMD_W(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    // Responder: 16-bit interval timer with one-cycle read latency.
    logic [31:0] resp_counter = 32'h0;
    logic [31:0] resp_snap    = 32'h0;
    logic        resp_to      = 1'b0;
    logic        resp_run     = 1'b0;
    logic        to_raise     = 1'b0;
    always @(posedge clk) begin
        if (bus.av_chipselect && !bus.av_write_n && bus.av_address == 3'd0) resp_to <= 1'b0;
        else if (to_raise) resp_to <= 1'b1;
        if (bus.av_chipselect && !bus.av_write_n && bus.av_address == 3'd1) begin
            if (bus.av_writedata[2]) resp_run <= 1'b1;
            else if (bus.av_writedata[3]) resp_run <= 1'b0;
        end
        if (bus.av_chipselect && !bus.av_write_n && bus.av_address == 3'd4) resp_snap <= resp_counter;
        if (bus.av_chipselect && bus.av_write_n) begin
            case (bus.av_address)
                3'd0:    bus.av_readdata <= {14'h0, resp_run, resp_to};
                3'd4:    bus.av_readdata <= resp_snap[15:0];
                3'd5:    bus.av_readdata <= resp_snap[31:16];
                default: bus.av_readdata <= 16'h0;
            endcase
        end else begin
            bus.av_readdata <= 16'h0;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Expectation model state, kept at the level of the timer's behaviour.
    logic        exp_run  = 1'b0;
    logic        exp_to   = 1'b0;
    logic        exp_cont = 1'b0;
    logic        exp_ien  = 1'b0;
    logic [31:0] exp_rsp  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [20:0] bw(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    function automatic logic [20:0] br(input logic [2:0] a);
        return {1'b1, 1'b1, a, 16'h0000};
    endfunction

    function automatic logic [20:0] bus_obs(input logic is_rd);
        return {bus.av_chipselect, bus.av_write_n, bus.av_address,
                is_rd ? 16'h0000 : bus.av_writedata};
    endfunction

    task automatic raise_to();
        @(negedge clk);
        to_raise = 1'b1;
        @(posedge clk);
        @(negedge clk);
        to_raise = 1'b0;
        exp_to   = 1'b1;
        #1;
    endtask

    // Presents a command, waits (bounded) for acceptance, returns at mid-cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] per, input logic c, input logic ie);
        int w = 0;
        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = op;
        bus.cmd_period     = per;
        bus.cmd_continuous = c;
        bus.cmd_irq_en     = ie;
        #1;
        while (!bus.cmd_ready && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("accept_wait", {31'h0, bus.cmd_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid      = 1'b0;
        bus.cmd_period     = $urandom;
        bus.cmd_continuous = 1'($urandom_range(0, 1));
        bus.cmd_irq_en     = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] per,
                           input logic c, input logic ie);
        logic [20:0] eb[$];
        logic        erd[$];
        case (op)
            OP_START: begin
                eb.push_back(bw(3'd2, per[15:0]));  erd.push_back(1'b0);
                eb.push_back(bw(3'd3, per[31:16])); erd.push_back(1'b0);
                eb.push_back(bw(3'd1, {12'h0, 2'b01, c, ie})); erd.push_back(1'b0);
                eb.push_back(IDLE_B); erd.push_back(1'b0);
                exp_cont = c;
                exp_ien  = ie;
                exp_run  = 1'b1;
            end
            OP_STOP: begin
                eb.push_back(bw(3'd1, {12'h0, 2'b10, exp_cont, exp_ien})); erd.push_back(1'b0);
                eb.push_back(IDLE_B); erd.push_back(1'b0);
                exp_run = 1'b0;
            end
            OP_SNAP: begin
                eb.push_back(bw(3'd4, 16'h0)); erd.push_back(1'b0);
                eb.push_back(br(3'd4));        erd.push_back(1'b1);
                eb.push_back(br(3'd5));        erd.push_back(1'b1);
                eb.push_back(IDLE_B);          erd.push_back(1'b0);
                eb.push_back(IDLE_B);          erd.push_back(1'b0);
                exp_rsp = resp_counter;
            end
            default: begin
                eb.push_back(br(3'd0)); erd.push_back(1'b1);
                eb.push_back(IDLE_B);   erd.push_back(1'b0);
                eb.push_back(exp_to ? bw(3'd0, 16'h0) : IDLE_B); erd.push_back(1'b0);
                eb.push_back(IDLE_B);   erd.push_back(1'b0);
                exp_rsp = {30'h0, exp_run, exp_to};
                exp_to  = 1'b0;
            end
        endcase
        issue(op, per, c, ie);
        for (int k = 0; k < eb.size(); k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("%s bus T+%0d", tag, k + 1), 32'(bus_obs(erd[k])), 32'(eb[k]));
            chk($sformatf("%s rsp_valid T+%0d", tag, k + 1), {31'h0, bus.rsp_valid},
                {31'h0, (k == eb.size() - 1)});
            chk($sformatf("%s timeout_pulse T+%0d", tag, k + 1), {31'h0, bus.timeout_pulse}, 32'h0);
        end
        chk($sformatf("%s cmd_ready at done", tag), {31'h0, bus.cmd_ready}, 32'h0);
        chk($sformatf("%s rsp_data", tag), bus.rsp_data, exp_rsp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] per;
        bus.cmd_valid      = 1'b0;
        bus.cmd_op         = 2'd0;
        bus.cmd_period     = 32'h0;
        bus.cmd_continuous = 1'b0;
        bus.cmd_irq_en     = 1'b0;
        bus.av_irq         = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("reset bus", 32'(bus_obs(1'b0)), 32'(IDLE_B));
        chk("reset cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        chk("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("reset rsp_data", bus.rsp_data, 32'h0);
        chk("reset timeout_pulse", {31'h0, bus.timeout_pulse}, 32'h0);
        chk("reset irq_count", {16'h0, bus.irq_count}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;

        // Directed scenarios.
        run_cmd("start_186a0", OP_START, 32'h0001_86A0, 1'b1, 1'b1);
        resp_counter = 32'h0001_2345;
        run_cmd("snap_12345", OP_SNAP, 32'h0, 1'b0, 1'b0);
        raise_to();
        run_cmd("status_to1", OP_STATUS, 32'h0, 1'b0, 1'b0);
        run_cmd("status_to0", OP_STATUS, 32'h0, 1'b0, 1'b0);

`ifdef TMR_MST_AUTO_ACK_EN
        raise_to();
        bus.av_irq         = 1'b1;
        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = OP_STOP;
        #1;
        chk("irq_prio cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            logic [20:0] e;
            @(negedge clk);
            if (k == 3) bus.av_irq = 1'b0;
            #1;
            e = (k == 1) ? br(3'd0) : (k == 3) ? bw(3'd0, 16'h0) : IDLE_B;
            chk($sformatf("irq_svc bus T+%0d", k), 32'(bus_obs(k == 1)), 32'(e));
            chk($sformatf("irq_svc rsp_valid T+%0d", k), {31'h0, bus.rsp_valid}, 32'h0);
            chk($sformatf("irq_svc timeout_pulse T+%0d", k), {31'h0, bus.timeout_pulse},
                {31'h0, (k == 4)});
        end
        exp_to = 1'b0;
        chk("irq_svc rsp_data held", bus.rsp_data, exp_rsp);
        run_cmd("stop_after_irq", OP_STOP, 32'h0, 1'b0, 1'b0);
        chk("irq_count after service", {16'h0, bus.irq_count}, 32'h1);
`else
        raise_to();
        bus.av_irq = 1'b1;
        run_cmd("stop_irq_ignored", OP_STOP, 32'h0, 1'b0, 1'b0);
        chk("irq_count ignored", {16'h0, bus.irq_count}, 32'h0);
        bus.av_irq = 1'b0;
`endif

        // Reset in the middle of a SNAPSHOT, during the high-half read.
        resp_counter = 32'hCAFE_0001;
        issue(OP_SNAP, 32'h0, 1'b0, 1'b0);
        chk("midreset snap write", 32'(bus_obs(1'b0)), 32'(bw(3'd4, 16'h0)));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset bus idle", 32'(bus_obs(1'b0)), 32'(IDLE_B));
        chk("midreset cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        chk("midreset rsp_data", bus.rsp_data, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("midreset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        end
        reset_n  = 1'b1;
        exp_cont = 1'b0;
        exp_ien  = 1'b0;
        exp_rsp  = 32'h0;
        @(negedge clk);
        #1;
        run_cmd("stop_after_reset", OP_STOP, 32'h0, 1'b0, 1'b0);

        // Randomized command stream against the model.
        for (int i = 0; i < 20; i++) begin
            op  = 2'($urandom_range(0, 3));
            per = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (op == OP_SNAP) resp_counter = $urandom;
            if (op == OP_STATUS && $urandom_range(0, 1) == 1) raise_to();
            run_cmd($sformatf("rand%0d", i), op, per, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
